rf_wb_arbiter: RTL

- Shares the single register-file write port (write enable, write address, write data) between N_REQ write-back requesters, e.g. ALU result, load data and a multicycle unit.
- Arbitration is round-robin over valid/ready handshakes.
- The winning request is registered and presented to the register file one cycle later.
- Sits between the execute/memory stages and the register file write port.

---
 rtl/rf_wb_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Round-robin arbiter sharing one register-file write port between N_REQ
// write-back requesters. Grants are combinational (valid/ready), and the
// winning write is registered onto the port one cycle after acceptance.
// Optional build macro: RF_WB_ZERO_FILTER_EN -- when defined, granted writes
// to register 0 are consumed but never raise rf_we or bump wr_count.

module rf_wb_arbiter #(
   parameter int unsigned N_REQ  = 3,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 16,
   localparam int unsigned SRC_W = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    stall,
   output logic                    rf_we,
   output logic [ADDR_W-1:0]       rf_waddr,
   output logic [DATA_W-1:0]       rf_wdata,
   output logic [SRC_W-1:0]        rf_wsrc,
   output logic [CNT_W-1:0]        wr_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Index reached by stepping 'offset' places past 'base', wrapping at N_REQ.
   function automatic logic [SRC_W-1:0] rr_index(input logic [SRC_W-1:0] base,
                                                 input int unsigned   offset);
      int unsigned sum;
      sum = {{(32-SRC_W){1'b0}}, base} + offset;
      if (sum >= N_REQ) begin
         sum = sum - N_REQ;
      end else begin
         sum = sum;
      end
      return sum[SRC_W-1:0];
   endfunction

   logic [SRC_W-1:0]  ptr;
   logic [SRC_W-1:0]  cand;
   logic [SRC_W-1:0]  win_idx;
   logic [SRC_W-1:0]  next_ptr;
   logic              found;
   logic              hit;
   logic              grant_taken;
   logic              commit;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_data;
   logic [ADDR_W-1:0] addr_arr [N_REQ];
   logic [DATA_W-1:0] data_arr [N_REQ];

   // Unpack the flat request buses into per-requester fields.
   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
   end

   // Round-robin search: first valid requester at or after ptr wins.
   always_comb begin
      found   = 1'b0;
      win_idx = {SRC_W{1'b0}};
      cand    = {SRC_W{1'b0}};
      hit     = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         cand    = rr_index(ptr, k);
         hit     = ~found & req_valid[cand];
         win_idx = hit ? cand : win_idx;
         found   = found | hit;
      end
   end

   // Grant qualification, ready vector and the winner's payload.
   always_comb begin
      grant_taken = found & ~stall & ~rst;
      req_ready   = grant_taken ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx)
                                : {N_REQ{1'b0}};
      win_addr    = addr_arr[win_idx];
      win_data    = data_arr[win_idx];
      next_ptr    = rr_index(win_idx, 32'd1);
`ifdef RF_WB_ZERO_FILTER_EN
      // Register 0 is hard-wired: consume the request but suppress the write.
      commit      = grant_taken & (win_addr != {ADDR_W{1'b0}});
`else
      commit      = grant_taken;
`endif
   end

   // Output register, round-robin pointer and saturating write counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= {SRC_W{1'b0}};
         rf_we    <= 1'b0;
         rf_waddr <= {ADDR_W{1'b0}};
         rf_wdata <= {DATA_W{1'b0}};
         rf_wsrc  <= {SRC_W{1'b0}};
         wr_count <= {CNT_W{1'b0}};
      end else begin
         rf_we <= commit;
         if (grant_taken) begin
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
            rf_wsrc  <= win_idx;
            ptr      <= next_ptr;
         end
         if (commit && (wr_count != CNT_MAX)) begin
            wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

endmodule
